// File: rtl/ps2_host_tx_if.sv
// Host-to-keyboard PS/2 transmit bundle: byte handshake, result pulses and pad controls.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       done;
  logic       ack_err;
  logic       timeout_err;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_valid, tx_data, ps2_clk_in, ps2_data_in,
    input  tx_ready, done, ack_err, timeout_err, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_valid, tx_data, ps2_clk_in, ps2_data_in,
    output tx_ready, done, ack_err, timeout_err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibit, request-to-send, shift 8 data + odd parity + stop, check device ACK.
//   state      | meaning
//   IDLE       | ready for a byte, lines released
//   INHIBIT    | clock held low; start bit asserted in the last cycle
//   RTS        | clock released, start bit held, timeout armed
//   SHIFT      | drive data/parity/stop on device falling edges
//   WAIT_ACK   | sample ACK on falling edge 11
//   WAIT_IDLE  | wait for both lines high
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  ps2_host_tx_if.slave bus
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_WAIT_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    idx_q;
  logic [7:0]    byte_q;
  logic          par_q;
  logic          bit_oe_q;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          done_q, ack_err_q, tmo_err_q;

  logic ready, accept, fall, cnt_zero, timing, tmo_hit;
  logic clk_oe, data_oe;

  assign fall     = clk_prev_q & ~clk_s2_q;
  assign cnt_zero = (cnt_q == '0);
  assign timing   = (state_q == S_RTS) || (state_q == S_SHIFT) || (state_q == S_WAIT_ACK);
  assign tmo_hit  = timing && cnt_zero;
  assign accept   = bus.tx_valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = S_INHIBIT;
      S_INHIBIT:   if (cnt_zero) state_d = S_RTS;
      S_RTS:       state_d = tmo_hit ? S_IDLE : S_SHIFT;
      S_SHIFT: begin
        if (tmo_hit)                        state_d = S_IDLE;
        else if (fall && idx_q == 4'd9)     state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tmo_hit)   state_d = S_IDLE;
        else if (fall) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: if (clk_s2_q && dat_s2_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs decode from the state register so rst releases the pads without waiting for a clock.
  always_comb begin
    ready   = 1'b0;
    clk_oe  = 1'b0;
    data_oe = 1'b0;
    case (state_q)
      S_IDLE:    ready   = !rst;
      S_INHIBIT: begin
        clk_oe  = 1'b1;
        data_oe = cnt_zero;
      end
      S_RTS:     data_oe = 1'b1;
      S_SHIFT:   data_oe = bit_oe_q;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      bit_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      clk_s1_q   <= bus.ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= bus.ps2_data_in;
      dat_s2_q   <= dat_s1_q;
      done_q     <= (state_q == S_WAIT_ACK) && fall && !tmo_hit && !dat_s2_q;
      ack_err_q  <= (state_q == S_WAIT_ACK) && fall && !tmo_hit &&  dat_s2_q;
      tmo_err_q  <= tmo_hit;
      if (timing && !cnt_zero) cnt_q <= cnt_q - CW'(1);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            byte_q <= bus.tx_data;
            par_q  <= ~^bus.tx_data;
            cnt_q  <= INH_LOAD;
          end
        end
        S_INHIBIT: begin
          if (cnt_zero) cnt_q <= TMO_LOAD;
          else          cnt_q <= cnt_q - CW'(1);
        end
        S_RTS: begin
          idx_q    <= '0;
          bit_oe_q <= 1'b1;
        end
        S_SHIFT: begin
          if (fall) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q < 4'd8)       bit_oe_q <= ~byte_q[idx_q[2:0]];
            else if (idx_q == 4'd8) bit_oe_q <= ~par_q;
            else                    bit_oe_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_ready    = ready;
  assign bus.ps2_clk_oe  = clk_oe;
  assign bus.ps2_data_oe = data_oe;
  assign bus.done        = done_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TMO  = 3000;
  localparam int HALF = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_ackerr = 0;
  int n_tmo = 0;

  ps2_host_tx_if bus();

  assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done)        n_done++;
    if (bus.ack_err)     n_ackerr++;
    if (bus.timeout_err) n_tmo++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int guard = 0;
    while (!bus.tx_ready && guard < 1000) begin
      tick();
      guard++;
    end
    ok = bus.tx_ready;
  endtask

  // Hand a byte over, then measure the inhibit window (cycles with clk_oe high).
  task automatic send_and_inhibit(input logic [7:0] b, output int inh_len,
                                  output int dpos, output int dcnt);
    bit ok;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ready_before_send: tx_ready=%b required 1", bus.tx_ready);
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    tick();
    bus.tx_valid = 1'b0;
    inh_len = 0;
    dpos = 0;
    dcnt = 0;
    while (bus.ps2_clk_oe && inh_len < 10 * INH) begin
      inh_len++;
      if (bus.ps2_data_oe) begin
        dpos = inh_len;
        dcnt++;
      end
      tick();
    end
  endtask

  // Device clocks nedges falling edges; line level sampled at the end of each low phase.
  task automatic dev_frame(input int nedges, input bit ack_low,
                           output logic [9:0] bits, output bit stable);
    logic snap;
    stable = 1'b1;
    bits = 'x;
    for (int e = 1; e <= nedges; e++) begin
      if (e == 11 && ack_low) dev_data = 1'b0;
      snap = bus.ps2_data_oe;
      repeat (HALF) begin
        tick();
        if (bus.ps2_data_oe !== snap) stable = 1'b0;
      end
      dev_clk = 1'b0;
      repeat (HALF) tick();
      if (e <= 10) bits[e-1] = bus.ps2_data_in;
      dev_clk = 1'b1;
    end
    repeat (2) tick();
    dev_data = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", bus.tx_ready); end
    n_checks++;
    if (bus.ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b required 0", bus.ps2_clk_oe); end
    n_checks++;
    if (bus.ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b required 0", bus.ps2_data_oe); end
    n_checks++;
    if ({bus.done, bus.ack_err, bus.timeout_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b required 000", {bus.done, bus.ack_err, bus.timeout_err});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", bus.tx_ready); end
    tick();
  endtask

  task automatic test_led_cmd();
    int inh, dpos, dcnt, bd, ba, bt;
    logic [9:0] bits;
    bit stable, ok;
    bd = n_done; ba = n_ackerr; bt = n_tmo;
    send_and_inhibit(8'hED, inh, dpos, dcnt);
    dev_frame(11, 1'b1, bits, stable);
    wait_ready(ok);
    n_checks++;
    if (inh !== INH) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d required %0d", inh, INH); end
    n_checks++;
    if (bits !== 10'b11_1110_1101) begin n_fail++; $display("FAIL ed_frame: got %b required %b", bits, 10'b11_1110_1101); end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL ed_data_stable: got %b required 1", stable); end
    n_checks++;
    if (n_done - bd !== 1) begin n_fail++; $display("FAIL ed_done_count: got %0d required 1", n_done - bd); end
    n_checks++;
    if ((n_ackerr - ba) + (n_tmo - bt) !== 0) begin
      n_fail++;
      $display("FAIL ed_err_pulses: got %0d required 0", (n_ackerr - ba) + (n_tmo - bt));
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ed_ready_return: got %b required 1", ok); end
  endtask

  task automatic test_parity_zero();
    int inh, dpos, dcnt, bd;
    logic [9:0] bits;
    bit stable, ok;
    bd = n_done;
    send_and_inhibit(8'h07, inh, dpos, dcnt);
    dev_frame(11, 1'b1, bits, stable);
    wait_ready(ok);
    n_checks++;
    if (inh !== INH) begin n_fail++; $display("FAIL p0_inhibit_len: got %0d required %0d", inh, INH); end
    n_checks++;
    if (dpos !== INH || dcnt !== 1) begin
      n_fail++;
      $display("FAIL p0_start_bit: got pos %0d cnt %0d required pos %0d cnt 1", dpos, dcnt, INH);
    end
    n_checks++;
    if (bits[8] !== 1'b0) begin n_fail++; $display("FAIL p0_parity_bit: got %b required 0", bits[8]); end
    n_checks++;
    if (bits !== 10'b10_0000_0111) begin n_fail++; $display("FAIL p0_frame: got %b required %b", bits, 10'b10_0000_0111); end
    n_checks++;
    if (n_done - bd !== 1) begin n_fail++; $display("FAIL p0_done_count: got %0d required 1", n_done - bd); end
  endtask

  task automatic test_ack_err();
    int inh, dpos, dcnt, bd, ba, bt;
    logic [9:0] bits;
    bit stable, ok;
    bd = n_done; ba = n_ackerr; bt = n_tmo;
    send_and_inhibit(8'h3C, inh, dpos, dcnt);
    dev_frame(11, 1'b0, bits, stable);
    wait_ready(ok);
    n_checks++;
    if (bits !== 10'b11_0011_1100) begin n_fail++; $display("FAIL ack_frame: got %b required %b", bits, 10'b11_0011_1100); end
    n_checks++;
    if (n_ackerr - ba !== 1) begin n_fail++; $display("FAIL ack_err_count: got %0d required 1", n_ackerr - ba); end
    n_checks++;
    if ((n_done - bd) + (n_tmo - bt) !== 0) begin
      n_fail++;
      $display("FAIL ack_other_pulses: got %0d required 0", (n_done - bd) + (n_tmo - bt));
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ack_ready_return: got %b required 1", ok); end
  endtask

  task automatic test_timeout();
    int inh, dpos, dcnt, k, bd, ba, bt;
    bd = n_done; ba = n_ackerr; bt = n_tmo;
    send_and_inhibit(8'h81, inh, dpos, dcnt);
    k = 0;
    while (!bus.timeout_err && k < TMO + 50) begin
      tick();
      k++;
    end
    n_checks++;
    if (k !== TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d required %0d", k, TMO); end
    n_checks++;
    if ({bus.ps2_clk_oe, bus.ps2_data_oe} !== 2'b00) begin
      n_fail++;
      $display("FAIL tmo_oe: got %b required 00", {bus.ps2_clk_oe, bus.ps2_data_oe});
    end
    tick();
    n_checks++;
    if (n_tmo - bt !== 1 || (n_done - bd) + (n_ackerr - ba) !== 0) begin
      n_fail++;
      $display("FAIL tmo_pulses: got tmo %0d other %0d required 1 and 0", n_tmo - bt, (n_done - bd) + (n_ackerr - ba));
    end
    n_checks++;
    if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready: got %b required 1", bus.tx_ready); end
  endtask

  task automatic test_reset_mid();
    int inh, dpos, dcnt, bd, ba, bt;
    logic [9:0] bits;
    bit stable, ok;
    bd = n_done; ba = n_ackerr; bt = n_tmo;
    send_and_inhibit(8'hA5, inh, dpos, dcnt);
    dev_frame(4, 1'b1, bits, stable);
    n_checks++;
    if (bus.ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL mid_pre_data_oe: got %b required 1", bus.ps2_data_oe); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b required 000", {bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_ready});
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ((n_done - bd) + (n_ackerr - ba) + (n_tmo - bt) !== 0) begin
      n_fail++;
      $display("FAIL mid_no_pulses: got %0d required 0", (n_done - bd) + (n_ackerr - ba) + (n_tmo - bt));
    end
    bd = n_done;
    send_and_inhibit(8'hA5, inh, dpos, dcnt);
    dev_frame(11, 1'b1, bits, stable);
    wait_ready(ok);
    n_checks++;
    if (bits !== 10'b11_1010_0101) begin n_fail++; $display("FAIL mid_refrm: got %b required %b", bits, 10'b11_1010_0101); end
    n_checks++;
    if (n_done - bd !== 1) begin n_fail++; $display("FAIL mid_done_count: got %0d required 1", n_done - bd); end
  endtask

  task automatic test_ignore_busy();
    int inh, dpos, dcnt, bd, seen_oe;
    logic [9:0] bits;
    bit stable, ok;
    logic rdy_at_poke;
    bd = n_done;
    send_and_inhibit(8'h5A, inh, dpos, dcnt);
    fork
      dev_frame(11, 1'b1, bits, stable);
      begin
        repeat (100) tick();
        rdy_at_poke = bus.tx_ready;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        tick();
        bus.tx_valid = 1'b0;
      end
    join
    wait_ready(ok);
    seen_oe = 0;
    repeat (40) begin
      tick();
      if (bus.ps2_clk_oe) seen_oe++;
    end
    n_checks++;
    if (rdy_at_poke !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b required 0", rdy_at_poke); end
    n_checks++;
    if (bits !== 10'b11_0101_1010) begin n_fail++; $display("FAIL busy_frame: got %b required %b", bits, 10'b11_0101_1010); end
    n_checks++;
    if (n_done - bd !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d required 1", n_done - bd); end
    n_checks++;
    if (seen_oe !== 0) begin n_fail++; $display("FAIL busy_not_queued: got %0d clk_oe cycles required 0", seen_oe); end
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    test_reset();
    test_led_cmd();
    test_parity_zero();
    test_ack_err();
    test_timeout();
    test_reset_mid();
    test_ignore_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clk cycles PS2 clock is held low before request-to-send (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles from clock release to ACK edge (20 ms at 100 MHz).
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tx_valid  input  1  request to send tx_data to the keyboard.
REQ-006 tx_data  input  8  byte to send (e.g. 0xED LED command).
REQ-007 tx_ready  output  1  high when idle and able to accept a byte.
REQ-008 ps2_clk_in  input  1  sampled PS2_CLK pad level.
REQ-009 ps2_data_in  input  1  sampled PS2_DATA pad level.
REQ-010 ps2_clk_oe  output  1  1 = drive PS2_CLK low, 0 = release (pull-up).
REQ-011 ps2_data_oe  output  1  1 = drive PS2_DATA low, 0 = release.
REQ-012 done  output  1  one-cycle pulse: byte sent and device ACK seen.
REQ-013 ack_err  output  1  one-cycle pulse: ACK bit sampled high.
REQ-014 timeout_err  output  1  one-cycle pulse: device failed to clock within TIMEOUT_CYCLES.

Function
REQ-015 ps2_clk_in and ps2_data_in shall pass through 2-flop synchronizers; a falling edge is synchronized clock previous=1, current=0.
REQ-016 States: IDLE, INHIBIT, RTS, SHIFT, WAIT_ACK, WAIT_IDLE.
REQ-017 IDLE: tx_ready=1, both oe=0; tx_valid&&tx_ready latches tx_data and parity = XNOR-reduce(tx_data) (odd parity) and enters INHIBIT next cycle.
REQ-018 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles; in the last cycle ps2_data_oe rises to 1 (start bit); then RTS.
REQ-019 RTS: ps2_clk_oe=0, ps2_data_oe=1; timeout counter cleared on entry; go to SHIFT, bit index 0.
REQ-020 SHIFT: on falling edges 1-8 drive data bit 0-7 (LSB first), edge 9 drive parity, edge 10 release data (stop); ps2_data_oe = NOT(bit); then WAIT_ACK.
REQ-021 Data changes only on synchronized falling edges; ps2_data_oe stable between edges.
REQ-022 WAIT_ACK: on falling edge 11 sample ps2_data_in sync; 0 -> done pulse; 1 -> ack_err pulse; either -> WAIT_IDLE.
REQ-023 WAIT_IDLE: both oe=0; return to IDLE when both synchronized lines are 1 for one cycle.
REQ-024 Timeout counter runs in RTS, SHIFT, WAIT_ACK; reaching TIMEOUT_CYCLES -> timeout_err pulse, both oe=0, go to IDLE directly.
REQ-025 tx_ready=0 in every state except IDLE; tx_valid while not ready is ignored, not queued.
REQ-026 done, ack_err, timeout_err mutually exclusive, each at most one pulse per transfer.
REQ-027 Counters sized to hold the larger parameter; no wrap-around before terminal count.

Reset
REQ-028 rst asynchronously forces IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=0 while asserted then 1 first cycle after release, done/ack_err/timeout_err=0, counters and latched byte cleared.
REQ-029 rst mid-transfer releases both lines immediately; the partial frame is abandoned, no error pulse.

Verification
REQ-030 tx_data=0xED, device model clocks 11 edges, ACK low -> data_oe bits 1,0,1,1,0,1,1,1, parity 1, stop released, done pulse once, tx_ready returns 1.
REQ-031 tx_data=0x07 -> parity bit 0 driven (ps2_data_oe=1 on edge 9); ps2_clk_oe high exactly INHIBIT_CYCLES cycles before release.
REQ-032 ACK bit left high on edge 11 -> ack_err pulse, no done, IDLE after lines high.
REQ-033 device never clocks after RTS -> timeout_err exactly TIMEOUT_CYCLES cycles after RTS entry, both oe=0.
REQ-034 rst asserted after edge 4 -> both oe=0 same cycle, no pulses; new tx_valid after reset sends full frame correctly.
REQ-035 tx_valid pulsed during SHIFT with different byte -> ignored; transmitted frame matches first byte.
